// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: counts lo..hi..lo for a latched number of round trips (0 = forever).
// Optional PAUSE_EN macro adds a pause input that freezes an active run.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic               abort,
`ifdef PAUSE_EN
  input  logic               pause,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   lo_l;
  logic [WIDTH-1:0]   hi_l;
  logic [SWEEP_W-1:0] sweeps_l;
  logic [SWEEP_W-1:0] sweep_cnt;
  logic [SWEEP_W-1:0] sweep_next;
  logic               step_en;

  assign sweep_next = sweep_cnt + SWEEP_W'(1);

`ifdef PAUSE_EN
  assign step_en = ~pause;
`else
  assign step_en = 1'b1;
`endif

  // NOTE: all state, including the outputs, uses non-blocking assignments so every
  // register samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      up_down   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      lo_l      <= '0;
      hi_l      <= '0;
      sweeps_l  <= '0;
      sweep_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lo < hi) begin
              lo_l      <= lo;
              hi_l      <= hi;
              sweeps_l  <= sweeps;
              sweep_cnt <= '0;
              count     <= lo;
              state     <= UP;
              up_down   <= 1'b1;
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        UP: begin
          if (abort) begin
            state   <= IDLE;
            up_down <= 1'b0;
            busy    <= 1'b0;
          end else if (step_en) begin
            if (count != hi_l) begin
              count <= count + WIDTH'(1);
            end else begin
              count   <= count - WIDTH'(1);
              state   <= DOWN;
              up_down <= 1'b0;
            end
          end
        end

        DOWN: begin
          if (abort) begin
            state   <= IDLE;
            up_down <= 1'b0;
            busy    <= 1'b0;
          end else if (step_en) begin
            if (count != lo_l) begin
              count <= count - WIDTH'(1);
            end else if (sweeps_l != '0 && sweep_next == sweeps_l) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // Later round trips restart one above lo so lo is not emitted twice in a row.
              sweep_cnt <= sweep_next;
              count     <= lo_l + WIDTH'(1);
              state     <= UP;
              up_down   <= 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          up_down <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count, lo and hi width.
REQ-002 SHALL have parameter SWEEP_W, default 4: sweeps width and internal sweep-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request a sweep run; sampled only in IDLE.
REQ-006 SHALL have port lo, input, WIDTH: lower bound; latched on accepted start.
REQ-007 SHALL have port hi, input, WIDTH: upper bound; latched on accepted start.
REQ-008 SHALL have port sweeps, input, SWEEP_W: number of round trips; latched on accepted start; 0 means run continuously.
REQ-009 SHALL have port abort, input, 1: terminate the run; highest priority after reset.
REQ-010 SHALL have port pause, input, 1: freeze the run; present only when PAUSE_EN is defined.
REQ-011 SHALL have port count, output, WIDTH: registered counter value.
REQ-012 SHALL have port up_down, output, 1: 1 in state UP, 0 otherwise.
REQ-013 SHALL have port busy, output, 1: 1 in states UP and DOWN.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-015 SHALL have port err, output, 1: one-cycle pulse on a rejected start.

Function
REQ-016 SHALL implement states IDLE, UP and DOWN; all outputs SHALL be registered.
REQ-017 In IDLE, start=1 with lo<hi SHALL: latch lo/hi/sweeps; set count=lo; clear the sweep counter; enter UP. busy=1 and count=lo SHALL be visible after that same edge.
REQ-018 In IDLE, start=1 with lo>=hi SHALL pulse err for one cycle; state SHALL remain IDLE and count SHALL hold.
REQ-019 In UP: count!=hi_l SHALL give count+1; count==hi_l SHALL give count-1 and enter DOWN.
REQ-020 In DOWN: count!=lo_l SHALL give count-1; count==lo_l completes one sweep.
REQ-021 On sweep completion with sweeps_l!=0 and (sweep counter+1)==sweeps_l: enter IDLE; busy=0; done=1 for one cycle; count holds lo_l.
REQ-022 On any other sweep completion: increment the sweep counter (wrapping at 2^SWEEP_W); count=lo_l+1; enter UP.
REQ-023 The sweep sequence SHALL be lo..hi..lo; busy duration SHALL be 2*(hi-lo)*sweeps+1 cycles.
REQ-024 abort=1 in UP or DOWN SHALL enter IDLE on the next edge: busy=0, count holds, done not asserted, err not asserted.
REQ-025 abort in IDLE SHALL have no effect.
REQ-026 abort and start together in IDLE: start SHALL win.
REQ-027 start while busy SHALL be ignored; changes on lo/hi/sweeps while busy SHALL be ignored.
REQ-028 count SHALL never leave [lo_l, hi_l] while busy.
REQ-029 In IDLE, count SHALL hold.

Reset
REQ-030 rst=0 SHALL asynchronously force: state IDLE; count=0; up_down=0; busy=0; done=0; err=0; lo_l/hi_l/sweeps_l/sweep counter=0.
REQ-031 rst asserted mid-run SHALL not produce a done pulse; release SHALL take effect on the next clk edge.

Configuration
REQ-032 Macro PAUSE_EN defined: the pause port SHALL exist. pause=1 in UP/DOWN SHALL hold count, state, up_down and the sweep counter; busy SHALL stay 1. abort SHALL override pause. pause SHALL be ignored in IDLE.
REQ-033 Macro PAUSE_EN undefined: the pause port and all its logic SHALL be absent; behaviour SHALL be otherwise identical.

Verification
REQ-034 lo=2, hi=5, sweeps=1, start pulse -> count 2,3,4,5,4,3,2; done pulse 7 cycles after start edge; busy high 7 cycles.
REQ-035 lo=0, hi=15, sweeps=2 -> count reaches 15 twice without wrap; done after 61 cycles; count=0 at end.
REQ-036 lo=7, hi=7 start, then lo=9, hi=3 start -> err pulse each time; busy stays 0; count unchanged.
REQ-037 sweeps=0, lo=1, hi=3; abort at cycle 20 -> count holds its value, busy=0 next edge, no done; new start is accepted afterwards.
REQ-038 rst=0 mid-DOWN, asynchronous to clk -> all outputs 0 immediately; no done.
REQ-039 With PAUSE_EN: pause for 3 cycles mid-UP at count=4 -> count=4 held 3 extra cycles; done delayed by 3 cycles. Then pause+abort together -> IDLE.
